link_datapath: RTL and testbench
================================

Name: link_datapath

Overview:
- Datapath responder for the player control FSM; the other end of the command/done interface.
- Executes each command level (init, idle, attack, up/down/left/right, draw) and returns the matching one-cycle done pulse.
- Owns player position, facing and attack flag.
- Drives the VGA adapter pixel-write port (160x120, 3-bit colour) to clear the screen, erase the old sprite and paint the new one.

Parameters:
- SCREEN_W, 160, screen width in pixels.
- SCREEN_H, 120, screen height in pixels.
- SPRITE_SIZE, 8, square sprite edge in pixels (power of two).
- START_X, 76, player x after init/reset.
- START_Y, 56, player y after init/reset.
- STEP, 1, pixels moved per move command.
- IDLE_CYCLES, 833333, idle cycles per idle_done pulse (60 Hz at 50 MHz).
- ATTACK_CYCLES, 8, cycles an attack command takes.
- BG_COLOUR, 3'b010, background colour.
- PLAYER_COLOUR, 3'b110, sprite colour.
- ATTACK_COLOUR, 3'b100, sprite colour while attack flag set.

Ports:
- clock  in  1  system clock, CLOCK_50
- reset  in  1  synchronous, active-high
- init  in  1  command: initialise
- idle  in  1  command: idle/wait for frame tick
- attack  in  1  command: attack
- up  in  1  command: move up
- down  in  1  command: move down
- left  in  1  command: move left
- right  in  1  command: move right
- draw  in  1  command: erase+redraw sprite
- init_done  out  1  one-cycle pulse
- idle_done  out  1  one-cycle pulse
- attack_done  out  1  one-cycle pulse
- move_done  out  1  one-cycle pulse
- draw_done  out  1  one-cycle pulse
- vga_x  out  8  pixel x
- vga_y  out  7  pixel y
- vga_colour  out  3  pixel colour
- vga_plot  out  1  write strobe
- pos_x  out  8  current player x (top-left)
- pos_y  out  7  current player y
- facing  out  2  00 up, 01 down, 10 left, 11 right

Behaviour:
- Reset (synchronous, active-high; clock is clock):
  - All done outputs 0, vga_plot 0, vga_x/vga_y/vga_colour 0.
  - pos_x=START_X, pos_y=START_Y, facing=01, attack flag 0, old-position regs = start position.
  - Internal FSM to WAIT; all counters 0.
  - Reset mid-operation aborts immediately; no done pulse is issued for the aborted command.
- Internal FSM states: WAIT, CLEAR, MOVE, ATK, ERASE, PAINT, DONE.
- Command acceptance (WAIT only):
  - Commands are levels held by the controller.
  - Priority when several are high: init > draw > attack > up > down > left > right > idle.
  - An accepted command is not re-accepted until it has been sampled low at least once (re-arm), so a held level yields exactly one done pulse.
  - Commands arriving while not in WAIT are ignored.
- init:
  - CLEAR writes BG_COLOUR to every pixel row-major, (0,0)..(SCREEN_W-1,SCREEN_H-1), with vga_plot=1 each cycle: 19200 cycles at defaults.
  - Position reset to START_X/START_Y, facing 01, attack flag 0.
  - init_done is high in the cycle after the last pixel write (DONE state), then the FSM returns to WAIT.
- idle:
  - While idle is high in WAIT and no other command is high, the idle counter increments each cycle.
  - idle_done pulses on the cycle the counter reaches IDLE_CYCLES-1; the counter then wraps to 0.
  - Counter clears whenever idle is low.
  - No re-arm rule for idle: a held idle level pulses periodically.
- move (up/down/left/right):
  - Command sampled at edge N: old-position regs <= pos and facing updated.
  - pos is then updated by STEP, saturating at 0 and at SCREEN_W-SPRITE_SIZE (x) / SCREEN_H-SPRITE_SIZE (y). No wrap-around.
  - move_done is high in cycle N+1.
  - A clamped move still updates facing and still pulses move_done; pos is unchanged.
- attack:
  - Sets attack flag; ATK lasts ATTACK_CYCLES cycles, then DONE pulses attack_done.
  - The attack flag stays set until the next completed draw, which clears it after painting.
- draw:
  - ERASE writes BG_COLOUR over the SPRITE_SIZE^2 block at the old position, row-major.
  - PAINT then writes the block at pos with ATTACK_COLOUR if the attack flag is set, else PLAYER_COLOUR.
  - draw_done is high in the cycle after the last PAINT pixel: 2*SPRITE_SIZE^2 plot cycles, then the pulse.
  - After draw, old-position regs <= pos.
- Pixel port: vga_x/vga_y/vga_colour are registered and valid whenever vga_plot=1. vga_plot=0 in all other states.
- Width rules:
  - Pixel counters are sized for SCREEN_W/SCREEN_H and SPRITE_SIZE.
  - Sprite pixel x = base + column, computed in 8 bits; never exceeds SCREEN_W-1 because of the clamp.

Test Plan:
- Reset, then init high until init_done -> exactly 19200 vga_plot cycles, last write (159,119,3'b010); init_done one cycle wide; pos=(76,56), facing=01.
- From (76,56): right high -> move_done in the next cycle; pos_x=77, facing=11. Holding right for 10 more cycles -> no further move_done (re-arm).
- Set pos_y=0 via repeated up moves, then up again -> move_done still pulses, pos_y stays 0, facing=00. Same at x=152 with right.
- After a move to (77,56), draw -> 64 writes of 3'b010 starting at (76,56), then 64 writes of 3'b110 starting at (77,56); draw_done is the cycle after write 128.
- Attack (ATTACK_CYCLES=8) -> attack_done 8 cycles after acceptance; following draw paints 3'b100; a second draw paints 3'b110.
- With IDLE_CYCLES=4 overridden, idle held -> idle_done every 4th cycle. Assert reset mid-draw -> vga_plot 0 the next cycle, no draw_done, pos=(76,56).

Source files
------------

// File: rtl/link_datapath_if.sv
// Link between the player control FSM and the datapath: command levels,
// done pulses, the VGA pixel-write port and the player state.
interface link_datapath_if;
  logic       init;
  logic       idle;
  logic       attack;
  logic       up;
  logic       down;
  logic       left;
  logic       right;
  logic       draw;
  logic       init_done;
  logic       idle_done;
  logic       attack_done;
  logic       move_done;
  logic       draw_done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic [7:0] pos_x;
  logic [6:0] pos_y;
  logic [1:0] facing;

  modport master (
    output init, idle, attack, up, down, left, right, draw,
    input  init_done, idle_done, attack_done, move_done, draw_done,
    input  vga_x, vga_y, vga_colour, vga_plot, pos_x, pos_y, facing
  );

  modport slave (
    input  init, idle, attack, up, down, left, right, draw,
    output init_done, idle_done, attack_done, move_done, draw_done,
    output vga_x, vga_y, vga_colour, vga_plot, pos_x, pos_y, facing
  );
endinterface

// File: rtl/link_datapath.sv
// Player datapath: answers controller commands with done pulses, keeps the
// player position/facing/attack flag and drives the VGA pixel-write port.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_WAIT  | accept the highest-priority armed command, count idle
// ST_CLEAR | paint the whole screen with the background colour
// ST_MOVE  | one cycle, move_done high (position already updated)
// ST_ATK   | attack in progress for ATTACK_CYCLES cycles
// ST_ERASE | background over the sprite block at the old position
// ST_PAINT | sprite block at the current position
// ST_DONE  | one cycle, done pulse for init/attack/draw
module link_datapath #(
  parameter int         SCREEN_W      = 160,
  parameter int         SCREEN_H      = 120,
  parameter int         SPRITE_SIZE   = 8,
  parameter int         START_X       = 76,
  parameter int         START_Y       = 56,
  parameter int         STEP          = 1,
  parameter int         IDLE_CYCLES   = 833333,
  parameter int         ATTACK_CYCLES = 8,
  parameter logic [2:0] BG_COLOUR     = 3'b010,
  parameter logic [2:0] PLAYER_COLOUR = 3'b110,
  parameter logic [2:0] ATTACK_COLOUR = 3'b100
) (
  input logic            clock,
  input logic            reset,
  link_datapath_if.slave bus
);
  localparam int SW    = (SPRITE_SIZE > 1) ? $clog2(SPRITE_SIZE) : 1;
  localparam int IW    = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam int AW    = (ATTACK_CYCLES > 1) ? $clog2(ATTACK_CYCLES) : 1;
  localparam int MAX_X = SCREEN_W - SPRITE_SIZE;
  localparam int MAX_Y = SCREEN_H - SPRITE_SIZE;

  // bit positions in the command vector, highest index wins
  localparam int C_RIGHT  = 0;
  localparam int C_LEFT   = 1;
  localparam int C_DOWN   = 2;
  localparam int C_UP     = 3;
  localparam int C_ATTACK = 4;
  localparam int C_DRAW   = 5;
  localparam int C_INIT   = 6;

  typedef enum logic [2:0] {
    ST_WAIT, ST_CLEAR, ST_MOVE, ST_ATK, ST_ERASE, ST_PAINT, ST_DONE
  } state_t;
  typedef enum logic [1:0] {OP_INIT, OP_ATTACK, OP_DRAW} op_t;

  state_t          state, state_n;
  op_t             op;
  logic [6:0]      cmd, armed, avail, accept;
  logic            idle_run;
  logic [IW-1:0]   idle_cnt;
  logic [7:0]      clr_x, clr_x_n;
  logic [6:0]      clr_y, clr_y_n;
  logic [SW-1:0]   col, col_n, row, row_n;
  logic [AW-1:0]   atk_cnt, atk_cnt_n;
  logic [7:0]      pos_x, old_x, mv_x, vga_x, vga_x_n;
  logic [6:0]      pos_y, old_y, mv_y, vga_y, vga_y_n;
  logic [1:0]      facing, mv_facing;
  logic [2:0]      vga_colour, vga_colour_n;
  logic            vga_plot, vga_plot_n;
  logic            atk_flag;

  assign cmd      = {bus.init, bus.draw, bus.attack, bus.up, bus.down, bus.left, bus.right};
  assign avail    = cmd & armed;
  assign idle_run = (state == ST_WAIT) && bus.idle && (cmd == '0);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_WAIT;
    else       state <= state_n;
  end

  // Next state, counter updates, next pixel and move target.
  always_comb begin
    state_n   = state;
    accept    = '0;
    clr_x_n   = clr_x;
    clr_y_n   = clr_y;
    col_n     = col;
    row_n     = row;
    atk_cnt_n = atk_cnt;
    case (state)
      ST_WAIT: begin
        if (avail[C_INIT]) begin
          accept[C_INIT] = 1'b1; state_n = ST_CLEAR; clr_x_n = '0; clr_y_n = '0;
        end else if (avail[C_DRAW]) begin
          accept[C_DRAW] = 1'b1; state_n = ST_ERASE; col_n = '0; row_n = '0;
        end else if (avail[C_ATTACK]) begin
          accept[C_ATTACK] = 1'b1; state_n = ST_ATK; atk_cnt_n = '0;
        end else if (avail[C_UP]) begin
          accept[C_UP] = 1'b1; state_n = ST_MOVE;
        end else if (avail[C_DOWN]) begin
          accept[C_DOWN] = 1'b1; state_n = ST_MOVE;
        end else if (avail[C_LEFT]) begin
          accept[C_LEFT] = 1'b1; state_n = ST_MOVE;
        end else if (avail[C_RIGHT]) begin
          accept[C_RIGHT] = 1'b1; state_n = ST_MOVE;
        end
      end
      ST_CLEAR: begin
        if (clr_x == 8'(SCREEN_W - 1)) begin
          clr_x_n = '0;
          if (clr_y == 7'(SCREEN_H - 1)) state_n = ST_DONE;
          else                           clr_y_n = clr_y + 7'd1;
        end else begin
          clr_x_n = clr_x + 8'd1;
        end
      end
      ST_MOVE: state_n = ST_WAIT;
      ST_ATK: begin
        if (atk_cnt == AW'(ATTACK_CYCLES - 1)) state_n = ST_DONE;
        else                                   atk_cnt_n = atk_cnt + AW'(1);
      end
      ST_ERASE, ST_PAINT: begin
        if (col == SW'(SPRITE_SIZE - 1)) begin
          col_n = '0;
          if (row == SW'(SPRITE_SIZE - 1)) begin
            row_n   = '0;
            state_n = (state == ST_ERASE) ? ST_PAINT : ST_DONE;
          end else begin
            row_n = row + SW'(1);
          end
        end else begin
          col_n = col + SW'(1);
        end
      end
      ST_DONE: state_n = ST_WAIT;
      default: state_n = ST_WAIT;
    endcase

    // The pixel registers are loaded with the pixel of the coming cycle so
    // that vga_plot is high exactly while the FSM sits in a plotting state.
    vga_x_n      = vga_x;
    vga_y_n      = vga_y;
    vga_colour_n = vga_colour;
    vga_plot_n   = 1'b0;
    case (state_n)
      ST_CLEAR: begin
        vga_x_n = clr_x_n; vga_y_n = clr_y_n; vga_colour_n = BG_COLOUR; vga_plot_n = 1'b1;
      end
      ST_ERASE: begin
        vga_x_n = old_x + 8'(col_n); vga_y_n = old_y + 7'(row_n);
        vga_colour_n = BG_COLOUR; vga_plot_n = 1'b1;
      end
      ST_PAINT: begin
        vga_x_n = pos_x + 8'(col_n); vga_y_n = pos_y + 7'(row_n);
        vga_colour_n = atk_flag ? ATTACK_COLOUR : PLAYER_COLOUR; vga_plot_n = 1'b1;
      end
      default: ;
    endcase

    mv_x      = pos_x;
    mv_y      = pos_y;
    mv_facing = facing;
    if (accept[C_UP]) begin
      mv_facing = 2'b00;
      mv_y      = (pos_y >= 7'(STEP)) ? pos_y - 7'(STEP) : '0;
    end else if (accept[C_DOWN]) begin
      mv_facing = 2'b01;
      mv_y      = (({1'b0, pos_y} + 8'(STEP)) >= 8'(MAX_Y)) ? 7'(MAX_Y) : pos_y + 7'(STEP);
    end else if (accept[C_LEFT]) begin
      mv_facing = 2'b10;
      mv_x      = (pos_x >= 8'(STEP)) ? pos_x - 8'(STEP) : '0;
    end else if (accept[C_RIGHT]) begin
      mv_facing = 2'b11;
      mv_x      = (({1'b0, pos_x} + 9'(STEP)) >= 9'(MAX_X)) ? 8'(MAX_X) : pos_x + 8'(STEP);
    end
  end

  // Datapath registers: re-arm tracking, counters, player state, pixel port.
  always_ff @(posedge clock) begin
    if (reset) begin
      armed      <= '1;
      idle_cnt   <= '0;
      clr_x      <= '0;
      clr_y      <= '0;
      col        <= '0;
      row        <= '0;
      atk_cnt    <= '0;
      op         <= OP_INIT;
      pos_x      <= 8'(START_X);
      pos_y      <= 7'(START_Y);
      old_x      <= 8'(START_X);
      old_y      <= 7'(START_Y);
      facing     <= 2'b01;
      atk_flag   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      // a command re-arms once it has been seen low
      armed      <= (armed & ~accept) | ~cmd;
      if (idle_run) idle_cnt <= (idle_cnt == IW'(IDLE_CYCLES - 1)) ? '0 : idle_cnt + IW'(1);
      else          idle_cnt <= '0;
      clr_x      <= clr_x_n;
      clr_y      <= clr_y_n;
      col        <= col_n;
      row        <= row_n;
      atk_cnt    <= atk_cnt_n;
      vga_x      <= vga_x_n;
      vga_y      <= vga_y_n;
      vga_colour <= vga_colour_n;
      vga_plot   <= vga_plot_n;
      if (accept[C_INIT]) begin
        op       <= OP_INIT;
        pos_x    <= 8'(START_X);
        pos_y    <= 7'(START_Y);
        old_x    <= 8'(START_X);
        old_y    <= 7'(START_Y);
        facing   <= 2'b01;
        atk_flag <= 1'b0;
      end
      if (accept[C_DRAW]) op <= OP_DRAW;
      if (accept[C_ATTACK]) begin
        op       <= OP_ATTACK;
        atk_flag <= 1'b1;
      end
      if (|accept[C_UP:C_RIGHT]) begin
        old_x  <= pos_x;
        old_y  <= pos_y;
        pos_x  <= mv_x;
        pos_y  <= mv_y;
        facing <= mv_facing;
      end
      if (state == ST_PAINT && state_n == ST_DONE) begin
        old_x    <= pos_x;
        old_y    <= pos_y;
        atk_flag <= 1'b0;
      end
    end
  end

  assign bus.init_done   = (state == ST_DONE) && (op == OP_INIT);
  assign bus.attack_done = (state == ST_DONE) && (op == OP_ATTACK);
  assign bus.draw_done   = (state == ST_DONE) && (op == OP_DRAW);
  assign bus.move_done   = (state == ST_MOVE);
  assign bus.idle_done   = idle_run && (idle_cnt == IW'(IDLE_CYCLES - 1));
  assign bus.vga_x       = vga_x;
  assign bus.vga_y       = vga_y;
  assign bus.vga_colour  = vga_colour;
  assign bus.vga_plot    = vga_plot;
  assign bus.pos_x       = pos_x;
  assign bus.pos_y       = pos_y;
  assign bus.facing      = facing;
endmodule

// File: tb/tb_link_datapath.sv
// Bench for link_datapath: reset state, init screen clear, moves with clamp,
// attack/draw colours, idle pulses, priority, reset mid-draw and random
// command sequences against a position/pixel model.
module tb_link_datapath;
  localparam int IDLE_N = 4;
  localparam int ATK_N  = 8;
  localparam int SPR    = 8;
  localparam int W      = 160;
  localparam int H      = 120;
  localparam int BG     = 2;
  localparam int PLAYER = 6;
  localparam int ATKCOL = 4;
  localparam int C_INIT = 0, C_IDLE = 1, C_ATTACK = 2, C_UP = 3, C_DOWN = 4,
                 C_LEFT = 5, C_RIGHT = 6, C_DRAW = 7;

  logic clock = 1'b0;
  logic reset = 1'b1;
  link_datapath_if bus();
  link_datapath #(.IDLE_CYCLES(IDLE_N)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int m_x, m_y, m_face, m_old_x, m_old_y;
  bit m_atk;
  int px_q[$], py_q[$], pc_q[$];
  int ex_q[$], ey_q[$], ec_q[$];

  typedef struct {
    int c; int x; int y; int face; int lat; int paint;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s: got %0d, wanted %0d", name, actual, expected);
    end
  endtask

  task automatic set_cmd(input int c, input logic v);
    case (c)
      C_INIT:   bus.init   = v;
      C_IDLE:   bus.idle   = v;
      C_ATTACK: bus.attack = v;
      C_UP:     bus.up     = v;
      C_DOWN:   bus.down   = v;
      C_LEFT:   bus.left   = v;
      C_RIGHT:  bus.right  = v;
      default:  bus.draw   = v;
    endcase
  endtask

  function automatic logic done_of(input int c);
    case (c)
      C_INIT:   return bus.init_done;
      C_IDLE:   return bus.idle_done;
      C_ATTACK: return bus.attack_done;
      C_DRAW:   return bus.draw_done;
      default:  return bus.move_done;
    endcase
  endfunction

  // Raise a command, record plots until its done pulse, drop it.
  task automatic do_cmd(input int c, input int budget, output int lat);
    px_q.delete(); py_q.delete(); pc_q.delete();
    lat = -1;
    set_cmd(c, 1'b1);
    for (int i = 1; i <= budget; i++) begin
      @(negedge clock);
      if (bus.vga_plot) begin
        px_q.push_back(int'(bus.vga_x));
        py_q.push_back(int'(bus.vga_y));
        pc_q.push_back(int'(bus.vga_colour));
      end
      if (done_of(c)) begin
        lat = i;
        break;
      end
    end
    set_cmd(c, 1'b0);
    if (lat < 0) begin
      total++; bad++;
      $display("FAIL done_timeout: cmd %0d got no done within %0d cycles", c, budget);
    end
    @(negedge clock);
    check("done_width", int'(done_of(c)), 0);
    check("plot_after_done", int'(bus.vga_plot), 0);
  endtask

  task automatic push_block(input int bx, input int by, input int col);
    for (int r = 0; r < SPR; r++)
      for (int cc = 0; cc < SPR; cc++) begin
        ex_q.push_back(bx + cc); ey_q.push_back(by + r); ec_q.push_back(col);
      end
  endtask

  // Run one command and compare with the model, then advance the model.
  task automatic run_cmd(input int c, output int lat);
    int exp_lat, errs;
    ex_q.delete(); ey_q.delete(); ec_q.delete();
    case (c)
      C_INIT: begin
        exp_lat = W * H + 1;
        for (int y = 0; y < H; y++)
          for (int x = 0; x < W; x++) begin
            ex_q.push_back(x); ey_q.push_back(y); ec_q.push_back(BG);
          end
      end
      C_ATTACK: exp_lat = ATK_N + 1;
      C_DRAW: begin
        exp_lat = 2 * SPR * SPR + 1;
        push_block(m_old_x, m_old_y, BG);
        push_block(m_x, m_y, m_atk ? ATKCOL : PLAYER);
      end
      default: exp_lat = 1;
    endcase
    do_cmd(c, exp_lat + 20, lat);
    check("latency", lat, exp_lat);
    check("plot_count", px_q.size(), ex_q.size());
    errs = 0;
    for (int i = 0; i < px_q.size() && i < ex_q.size(); i++)
      if (px_q[i] != ex_q[i] || py_q[i] != ey_q[i] || pc_q[i] != ec_q[i]) errs++;
    check("plot_stream_errors", errs, 0);
    case (c)
      C_INIT: begin
        m_x = 76; m_y = 56; m_face = 1; m_atk = 0; m_old_x = 76; m_old_y = 56;
      end
      C_ATTACK: m_atk = 1;
      C_DRAW: begin
        m_old_x = m_x; m_old_y = m_y; m_atk = 0;
      end
      C_UP: begin
        m_old_x = m_x; m_old_y = m_y; m_face = 0; m_y = (m_y > 0) ? m_y - 1 : 0;
      end
      C_DOWN: begin
        m_old_x = m_x; m_old_y = m_y; m_face = 1; m_y = (m_y < H - SPR) ? m_y + 1 : H - SPR;
      end
      C_LEFT: begin
        m_old_x = m_x; m_old_y = m_y; m_face = 2; m_x = (m_x > 0) ? m_x - 1 : 0;
      end
      default: begin
        m_old_x = m_x; m_old_y = m_y; m_face = 3; m_x = (m_x < W - SPR) ? m_x + 1 : W - SPR;
      end
    endcase
    check("pos_x", int'(bus.pos_x), m_x);
    check("pos_y", int'(bus.pos_y), m_y);
    check("facing", int'(bus.facing), m_face);
  endtask

  initial begin
    int lat, seen, r;
    vecs[0] = '{C_RIGHT, 78, 56, 3, 1, -1};
    vecs[1] = '{C_DOWN, 78, 57, 1, 1, -1};
    vecs[2] = '{C_LEFT, 77, 57, 2, 1, -1};
    vecs[3] = '{C_UP, 77, 56, 0, 1, -1};
    vecs[4] = '{C_ATTACK, 77, 56, 0, 9, -1};
    vecs[5] = '{C_DRAW, 77, 56, 0, 129, ATKCOL};
    vecs[6] = '{C_DRAW, 77, 56, 0, 129, PLAYER};

    bus.init = 0; bus.idle = 0; bus.attack = 0; bus.up = 0;
    bus.down = 0; bus.left = 0; bus.right = 0; bus.draw = 0;
    repeat (3) @(negedge clock);
    check("rst_plot", int'(bus.vga_plot), 0);
    check("rst_vga_x", int'(bus.vga_x), 0);
    check("rst_dones", int'({bus.init_done, bus.idle_done, bus.attack_done,
                             bus.move_done, bus.draw_done}), 0);
    check("rst_pos_x", int'(bus.pos_x), 76);
    check("rst_pos_y", int'(bus.pos_y), 56);
    check("rst_facing", int'(bus.facing), 1);
    reset = 0;
    m_x = 76; m_y = 56; m_face = 1; m_atk = 0; m_old_x = 76; m_old_y = 56;

    run_cmd(C_INIT, lat);
    check("init_writes", px_q.size(), 19200);
    if (px_q.size() > 0) begin
      check("init_last_x", px_q[px_q.size()-1], 159);
      check("init_last_y", py_q[py_q.size()-1], 119);
      check("init_last_c", pc_q[pc_q.size()-1], BG);
    end

    // right held: one move only
    bus.right = 1;
    @(negedge clock);
    check("right_move_done", int'(bus.move_done), 1);
    check("right_pos_x", int'(bus.pos_x), 77);
    check("right_facing", int'(bus.facing), 3);
    seen = 0;
    repeat (10) begin
      @(negedge clock);
      if (bus.move_done) seen++;
    end
    check("right_rearm_extra_dones", seen, 0);
    bus.right = 0;
    @(negedge clock);
    m_old_x = 76; m_old_y = 56; m_x = 77; m_face = 3;

    run_cmd(C_DRAW, lat);
    if (px_q.size() == 128) begin
      check("draw_first_erase_x", px_q[0], 76);
      check("draw_first_erase_c", pc_q[0], BG);
      check("draw_first_paint_x", px_q[64], 77);
      check("draw_first_paint_y", py_q[64], 56);
      check("draw_first_paint_c", pc_q[64], PLAYER);
    end

    for (int i = 0; i < 7; i++) begin
      run_cmd(vecs[i].c, lat);
      check("vec_latency", lat, vecs[i].lat);
      check("vec_pos_x", int'(bus.pos_x), vecs[i].x);
      check("vec_pos_y", int'(bus.pos_y), vecs[i].y);
      check("vec_facing", int'(bus.facing), vecs[i].face);
      if (vecs[i].paint >= 0)
        check("vec_paint_colour", (pc_q.size() > 64) ? pc_q[64] : -1, vecs[i].paint);
    end

    // clamps on all four edges
    while (m_y > 0) run_cmd(C_UP, lat);
    run_cmd(C_UP, lat);
    check("clamp_up_lat", lat, 1);
    check("clamp_up_y", int'(bus.pos_y), 0);
    check("clamp_up_face", int'(bus.facing), 0);
    while (m_x < W - SPR) run_cmd(C_RIGHT, lat);
    run_cmd(C_RIGHT, lat);
    check("clamp_right_lat", lat, 1);
    check("clamp_right_x", int'(bus.pos_x), 152);
    run_cmd(C_DRAW, lat);
    while (m_y < H - SPR) run_cmd(C_DOWN, lat);
    run_cmd(C_DOWN, lat);
    check("clamp_down_y", int'(bus.pos_y), 112);
    while (m_x > 0) run_cmd(C_LEFT, lat);
    run_cmd(C_LEFT, lat);
    check("clamp_left_x", int'(bus.pos_x), 0);
    check("clamp_left_face", int'(bus.facing), 2);

    // priority: attack beats right; right is served afterwards
    bus.attack = 1; bus.right = 1;
    @(negedge clock);
    check("prio_no_move", int'(bus.move_done), 0);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (bus.attack_done) begin lat = i; break; end
    end
    check("prio_attack_lat", lat, ATK_N);
    bus.attack = 0;
    lat = -1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clock);
      if (bus.move_done) begin lat = i; break; end
    end
    check("prio_right_after", lat, 2);
    bus.right = 0;
    @(negedge clock);
    m_atk = 1; m_old_x = m_x; m_old_y = m_y; m_x = m_x + 1; m_face = 3;
    check("prio_pos_x", int'(bus.pos_x), m_x);

    // random commands against the model
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 6);
      case (r)
        0: run_cmd(C_UP, lat);
        1: run_cmd(C_DOWN, lat);
        2: run_cmd(C_LEFT, lat);
        3: run_cmd(C_RIGHT, lat);
        4: run_cmd(C_ATTACK, lat);
        default: run_cmd(C_DRAW, lat);
      endcase
    end

    // idle: pulse on every IDLE_N-th cycle of a continuous idle level
    bus.idle = 1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clock);
      check("idle_done_cycle", int'(bus.idle_done), int'(((i + 1) % IDLE_N) == 0));
    end
    bus.idle = 0;
    repeat (3) begin
      @(negedge clock);
      check("idle_low_no_done", int'(bus.idle_done), 0);
    end
    bus.idle = 1;
    for (int i = 1; i <= IDLE_N; i++) begin
      @(negedge clock);
      check("idle_restart_cycle", int'(bus.idle_done), int'(((i + 1) % IDLE_N) == 0));
    end
    bus.idle = 0;
    @(negedge clock);

    // move somewhere, then reset in the middle of a draw
    run_cmd(C_RIGHT, lat);
    bus.draw = 1;
    repeat (20) @(negedge clock);
    check("mid_draw_plot", int'(bus.vga_plot), 1);
    reset = 1; bus.draw = 0;
    @(negedge clock);
    check("abort_plot", int'(bus.vga_plot), 0);
    check("abort_pos_x", int'(bus.pos_x), 76);
    check("abort_pos_y", int'(bus.pos_y), 56);
    check("abort_facing", int'(bus.facing), 1);
    reset = 0;
    seen = 0;
    repeat (140) begin
      @(negedge clock);
      if (bus.draw_done || bus.vga_plot) seen++;
    end
    check("abort_no_draw_activity", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
